fp_unpack_class: RTL and testbench
==================================

Name: fp_unpack_class

Overview:
- Streaming single-precision unpacker/classifier; the decomposition counterpart of the sign-injection composer in the FP ALU.
- Splits an IEEE-754 binary32 operand into sign, unbiased normalized exponent and normalized 24-bit significand.
- Produces the RISC-V fclass one-hot mask.
- 2-stage valid/ready pipeline between the FP register-read stage and multi-cycle FP units (div/sqrt).

Parameters:
- EXP_W, 8, input exponent field width
- FRAC_W, 23, input fraction field width
- OUT_EXP_W, 10, signed unbiased exponent output width; must hold the range -149..+128

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  operand valid
- in_ready  out  1  unit can accept an operand this cycle
- rs1  in  32  binary32 operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sign  out  1  sign bit
- out_exp  out  OUT_EXP_W  two's-complement unbiased exponent
- out_mant  out  FRAC_W+1  normalized significand, MSB = leading 1
- out_class  out  10  fclass one-hot mask

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, out_valid=0, out_sign=0, out_exp=0, out_mant=0, out_class=0. After release, in_ready=1.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_* data held stable while out_valid & !out_ready.
- Stall/ready rules:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational, no dependence on in_valid).
- Latency: 2 cycles from accept to out_valid when not stalled. Throughput: 1 operand/cycle. Capacity: 2 entries. Strict order; no drop, no duplicate.
- Stage 1 registers sign, raw exp, frac, class mask and lz.
  - lz = leading-zero count of the 23-bit frac, range 0..23.
- Class mask bits, exactly one set:
  - 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0
  - 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN
  - NaN (E=255, frac!=0): qNaN if frac[22]=1, else sNaN; sign ignored.
- Stage 2 normalization:
  - normal (1<=E<=254): exp = E-127; mant = {1,frac}
  - subnormal (E=0, frac!=0): exp = -127-lz; mant = {frac,0} << lz (MSB=1)
  - zero: exp = 0; mant = 0
  - inf/NaN (E=255): exp = +128; mant = {1,frac}
- flush: clears s1_valid and out_valid at the next edge. Data regs are don't-care. flush wins over simultaneous accept; the input is not taken.
- Simultaneous accept and output transfer in the same cycle is legal and keeps a full pipeline streaming.
- Reset asserted mid-operation discards all in-flight entries immediately.

Decomposition:
- Shared package fp_pkg holds:
  - BIAS=127, EXP_MAX=255, SUBNORM_EXP=-127
  - class bit-index constants CLS_NINF..CLS_QNAN (0..9)
  - an fp32 field struct {sign, exp, frac}
  - fsgnj and fclass users share this package.
- One sub-module: lzc23 (combinational 23-bit leading-zero counter; output 5 bits; returns 23 for all-zero input).

Test Plan:
- 0x3F800000, out_ready=1 -> 2 cycles later: out_class=0x040, sign=0, exp=0, mant=0x800000.
- 0x00000001 -> class=0x020, exp=0x36B (-149), mant=0x800000. 0x00400000 -> exp=-127 (0x381), mant=0x800000.
- Special values:
  - 0xFF800000 -> class=0x001, sign=1, exp=128, mant=0x800000
  - 0x7FC00000 -> class=0x200
  - 0x7F800001 -> class=0x100
  - 0x80000000 -> class=0x008, exp=0, mant=0
- Backpressure:
  - Setup: out_ready=0, stream A,B,C on consecutive cycles.
  - Required: A and B accepted; in_ready=0 while C is offered; out_* holds A stably.
  - Then raise out_ready: results A, B, C emerge in order, one per cycle, none lost.
- Flush with 2 entries in flight plus in_valid high -> next cycle out_valid=0 and s1 empty; the concurrent input is not accepted (no phantom output).
- rst_n pulsed low asynchronously mid-stream (between edges) -> out_valid drops immediately; outputs read 0; in_ready=1 after release; a fresh operand yields a correct result 2 cycles later.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared binary32 field layout, exponent constants and fclass bit positions
// for the FP unpack/classify and sign-injection paths.
package fp_pkg;

    localparam int unsigned BIAS        = 127;
    localparam int unsigned EXP_MAX     = 255;
    localparam int          SUBNORM_EXP = -127;

    localparam int unsigned CLS_W     = 10;
    localparam int unsigned CLS_NINF  = 0;
    localparam int unsigned CLS_NNORM = 1;
    localparam int unsigned CLS_NSUB  = 2;
    localparam int unsigned CLS_NZERO = 3;
    localparam int unsigned CLS_PZERO = 4;
    localparam int unsigned CLS_PSUB  = 5;
    localparam int unsigned CLS_PNORM = 6;
    localparam int unsigned CLS_PINF  = 7;
    localparam int unsigned CLS_SNAN  = 8;
    localparam int unsigned CLS_QNAN  = 9;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/lzc23.sv
// Combinational leading-zero counter for a 23-bit fraction; all-zero gives 23.
module lzc23 (
    input  logic [22:0] in_bits,
    output logic [4:0]  lz
);

    logic found;

    always_comb begin
        lz    = 5'd23;
        found = 1'b0;
        for (int i = 22; i >= 0; i--) begin
            if (!found && in_bits[i]) begin
                lz    = 5'(22 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_unpack_class.sv
// Two-stage valid/ready binary32 unpacker: stage 1 classifies and counts
// leading zeros, stage 2 produces unbiased exponent and normalized significand.
module fp_unpack_class
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned FRAC_W    = 23,
    parameter int unsigned OUT_EXP_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          rs1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [OUT_EXP_W-1:0] out_exp,
    output logic [FRAC_W:0]      out_mant,
    output logic [CLS_W-1:0]     out_class
);

    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned LZ_W   = 5;

    fp32_t op;
    assign op = rs1;

    logic [LZ_W-1:0] lz_c;
    logic [3:0]      cls_idx_c;
    logic [CLS_W-1:0] cls_c;

    lzc23 u_lzc (
        .in_bits (op.frac),
        .lz      (lz_c)
    );

    // fclass decode of the incoming operand
    always_comb begin
        cls_idx_c = 4'(CLS_PNORM);
        if (op.exp == '1) begin
            if (op.frac == '0) cls_idx_c = op.sign ? 4'(CLS_NINF) : 4'(CLS_PINF);
            else               cls_idx_c = op.frac[22] ? 4'(CLS_QNAN) : 4'(CLS_SNAN);
        end else if (op.exp == '0) begin
            if (op.frac == '0) cls_idx_c = op.sign ? 4'(CLS_NZERO) : 4'(CLS_PZERO);
            else               cls_idx_c = op.sign ? 4'(CLS_NSUB) : 4'(CLS_PSUB);
        end else begin
            cls_idx_c = op.sign ? 4'(CLS_NNORM) : 4'(CLS_PNORM);
        end
        cls_c = CLS_W'(1) << cls_idx_c;
    end

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q,  s1_sign_d;
    logic [EXP_W-1:0]     s1_exp_q,   s1_exp_d;
    logic [FRAC_W-1:0]    s1_frac_q,  s1_frac_d;
    logic [CLS_W-1:0]     s1_class_q, s1_class_d;
    logic [LZ_W-1:0]      s1_lz_q,    s1_lz_d;

    logic                 out_valid_q, out_valid_d;
    logic                 out_sign_q,  out_sign_d;
    logic [OUT_EXP_W-1:0] out_exp_q,   out_exp_d;
    logic [MANT_W-1:0]    out_mant_q,  out_mant_d;
    logic [CLS_W-1:0]     out_class_q, out_class_d;

    logic s2_adv_c, s1_adv_c, accept_c;

    assign s2_adv_c = !out_valid_q || out_ready;
    assign s1_adv_c = !s1_valid_q || s2_adv_c;
    assign accept_c = in_valid && s1_adv_c && !flush;
    assign in_ready = s1_adv_c;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_frac_d   = s1_frac_q;
        s1_class_d  = s1_class_q;
        s1_lz_d     = s1_lz_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_mant_d  = out_mant_q;
        out_class_d = out_class_q;

        if (s2_adv_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sign_d  = s1_sign_q;
                out_class_d = s1_class_q;
                if (s1_exp_q == EXP_W'(EXP_MAX)) begin
                    out_exp_d  = OUT_EXP_W'(EXP_MAX - BIAS);
                    out_mant_d = {1'b1, s1_frac_q};
                end else if (s1_exp_q != '0) begin
                    out_exp_d  = OUT_EXP_W'(s1_exp_q) - OUT_EXP_W'(BIAS);
                    out_mant_d = {1'b1, s1_frac_q};
                end else if (s1_frac_q != '0) begin
                    // subnormal: shift the first set fraction bit up to the MSB
                    out_exp_d  = OUT_EXP_W'(SUBNORM_EXP) - OUT_EXP_W'(s1_lz_q);
                    out_mant_d = MANT_W'({s1_frac_q, 1'b0} << s1_lz_q);
                end else begin
                    out_exp_d  = '0;
                    out_mant_d = '0;
                end
            end
        end

        if (s1_adv_c) begin
            s1_valid_d = accept_c;
            if (accept_c) begin
                s1_sign_d  = op.sign;
                s1_exp_d   = op.exp;
                s1_frac_d  = op.frac;
                s1_class_d = cls_c;
                s1_lz_d    = lz_c;
            end
        end

        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_frac_q   <= '0;
            s1_class_q  <= '0;
            s1_lz_q     <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
            out_class_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_frac_q   <= s1_frac_d;
            s1_class_q  <= s1_class_d;
            s1_lz_q     <= s1_lz_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_mant_q  <= out_mant_d;
            out_class_q <= out_class_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_mant  = out_mant_q;
    assign out_class = out_class_q;

endmodule

// File: tb/tb_fp_unpack_class.sv
// Self-checking bench for fp_unpack_class: constant vectors, directed
// backpressure/flush/reset sequences and a randomized scoreboarded stream.
module tb_fp_unpack_class;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [9:0]  out_exp;
    logic [23:0] out_mant;
    logic [9:0]  out_class;

    fp_unpack_class dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_class (out_class)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] mant;
        logic [9:0]  cls;
    } res_t;

    typedef struct {
        logic [31:0] rs1;
        logic [9:0]  cls;
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] mant;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t exp_q[$];
    logic mon_en = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_flush = 1'b0;
    logic [44:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: value-level reasoning about binary32, not bit slicing of fields
    function automatic res_t model(input logic [31:0] x);
        res_t r;
        int   e, f, m, ex, c;
        r.sign = x[31];
        e = int'(x[30:23]);
        f = int'(x[22:0]);
        if (e == 255) begin
            if (f == 0) c = x[31] ? 0 : 7;
            else        c = (f >= (1 << 22)) ? 9 : 8;
            ex = 128;
            m  = (1 << 23) + f;
        end else if (e == 0 && f == 0) begin
            c  = x[31] ? 3 : 4;
            ex = 0;
            m  = 0;
        end else if (e == 0) begin
            c  = x[31] ? 2 : 5;
            m  = f;
            ex = -126;
            while (m < (1 << 23)) begin
                m  = m * 2;
                ex = ex - 1;
            end
        end else begin
            c  = x[31] ? 1 : 6;
            ex = e - 127;
            m  = (1 << 23) + f;
        end
        r.exp  = 10'(ex);
        r.mant = 24'(m);
        r.cls  = 10'(1 << c);
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 5);
        case (k)
            0: v[30:0] = '0;
            1: begin v[30:23] = '0; v[22:0] = v[22:0] >> $urandom_range(0, 22); end
            2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            3: v[30:23] = 8'hFF;
            default: ;
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: checks in_ready, ordering, data and stall-hold every cycle
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            res_t e;
            if (prev_stall && !prev_flush) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'({out_sign, out_exp, out_mant, out_class}), 64'(prev_data));
            end
            chk("in_ready", 64'(in_ready), 64'((exp_q.size() < 2) || out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("phantom_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", 64'({out_sign, out_exp, out_mant, out_class}),
                        64'({e.sign, e.exp, e.mant, e.cls}));
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(model(rs1));
            prev_stall = out_valid && !out_ready;
            prev_flush = flush;
            prev_data  = {out_sign, out_exp, out_mant, out_class};
        end else begin
            prev_stall = 1'b0;
        end
    end

    vec_t vecs[10];
    res_t ra, rb, rc, rf;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rs1 = '0;
        vecs[0] = '{32'h3F800000, 10'h040, 1'b0, 10'h000, 24'h800000};
        vecs[1] = '{32'h00000001, 10'h020, 1'b0, 10'h36B, 24'h800000};
        vecs[2] = '{32'h00400000, 10'h020, 1'b0, 10'h381, 24'h800000};
        vecs[3] = '{32'hFF800000, 10'h001, 1'b1, 10'h080, 24'h800000};
        vecs[4] = '{32'h7FC00000, 10'h200, 1'b0, 10'h080, 24'hC00000};
        vecs[5] = '{32'h7F800001, 10'h100, 1'b0, 10'h080, 24'h800001};
        vecs[6] = '{32'h80000000, 10'h008, 1'b1, 10'h000, 24'h000000};
        vecs[7] = '{32'h807FFFFF, 10'h004, 1'b1, 10'h381, 24'hFFFFFE};
        vecs[8] = '{32'hC0490FDB, 10'h002, 1'b1, 10'h001, 24'hC90FDB};
        vecs[9] = '{32'h00000000, 10'h010, 1'b0, 10'h000, 24'h000000};

        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'({out_sign, out_exp, out_mant, out_class}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        mon_en = 1'b1;

        // Constant vectors, 2-cycle latency each
        foreach (vecs[i]) begin
            step();
            in_valid = 1'b1; rs1 = vecs[i].rs1;
            step();
            in_valid = 1'b0;
            step();
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_class", i), 64'(out_class), 64'(vecs[i].cls));
            chk($sformatf("vec%0d_sign", i), 64'(out_sign), 64'(vecs[i].sign));
            chk($sformatf("vec%0d_exp", i), 64'(out_exp), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_mant", i), 64'(out_mant), 64'(vecs[i].mant));
        end
        step(); step();

        // Backpressure: A, B accepted, C held off until the consumer drains
        ra = model(32'h3F800000); rb = model(32'h80000000); rc = model(32'h7FC00000);
        out_ready = 1'b0;
        in_valid = 1'b1; rs1 = 32'h3F800000;
        step(); rs1 = 32'h80000000;
        step(); rs1 = 32'h7FC00000;
        #3 chk("bp_c_blocked", 64'(in_ready), 64'd0);
        step();
        chk("bp_hold_a", 64'({out_valid, out_class, out_mant}), 64'({1'b1, ra.cls, ra.mant}));
        step();
        out_ready = 1'b1;
        #3 chk("bp_out_a", 64'({out_valid, out_class, out_mant}), 64'({1'b1, ra.cls, ra.mant}));
        step();
        in_valid = 1'b0;
        #3 chk("bp_out_b", 64'({out_valid, out_class, out_mant}), 64'({1'b1, rb.cls, rb.mant}));
        step();
        #3 chk("bp_out_c", 64'({out_valid, out_class, out_mant}), 64'({1'b1, rc.cls, rc.mant}));
        step();
        #3 chk("bp_drained", 64'(out_valid), 64'd0);
        step();

        // Flush with two in flight plus a concurrent offer
        out_ready = 1'b0;
        in_valid = 1'b1; rs1 = 32'h40000000;
        step(); rs1 = 32'h40400000;
        step(); rs1 = 32'h40800000; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush_no_phantom", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset between edges while streaming
        in_valid = 1'b1; rs1 = 32'h3F800000;
        step(); rs1 = 32'h40000000;
        step(); rs1 = 32'h40400000;
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_outputs", 64'({out_sign, out_exp, out_mant, out_class}), 64'd0);
        rst_n = 1'b1;
        #1 chk("arst_in_ready", 64'(in_ready), 64'd1);
        rf = model(32'hBF000000);
        step();
        in_valid = 1'b1; rs1 = 32'hBF000000;
        step();
        in_valid = 1'b0;
        step();
        chk("post_rst_result", 64'({out_valid, out_sign, out_exp, out_mant, out_class}),
            64'({1'b1, rf.sign, rf.exp, rf.mant, rf.cls}));

        // Randomized stream against the scoreboard
        for (int k = 0; k < 600; k++) begin
            step();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rs1       = rand_fp();
        end
        step();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
